// File: rtl/conv1d_ctrl_fsm_if.sv
// Beat bus between the conv1d sequencing controller and the MAC datapath.
// Latency: n/a (wires only); the controller registers every field it drives.
// Backpressure: plain valid/ready; fields hold while beat_valid_o & !beat_ready_i.
//
// Signals (named from the controller's point of view):
//   beat_valid_o  controller -> datapath  beat available
//   beat_ready_i  datapath -> controller  beat accepted
//   in_idx_o      controller -> datapath  input sample index (out_idx + tap)
//   tap_idx_o     controller -> datapath  kernel tap index
//   out_idx_o     controller -> datapath  output sample index
//   first_o       controller -> datapath  first tap of window (clear accumulator)
//   last_o        controller -> datapath  last tap of window (write result)
interface conv1d_ctrl_fsm_if #(
  parameter int LEN_W = 16,
  parameter int K_W   = 4
);
  logic             beat_valid_o;
  logic             beat_ready_i;
  logic [LEN_W-1:0] in_idx_o;
  logic [K_W-1:0]   tap_idx_o;
  logic [LEN_W-1:0] out_idx_o;
  logic             first_o;
  logic             last_o;

  // Controller side.
  modport master (
    output beat_valid_o,
    output in_idx_o,
    output tap_idx_o,
    output out_idx_o,
    output first_o,
    output last_o,
    input  beat_ready_i
  );

  // Datapath side.
  modport slave (
    input  beat_valid_o,
    input  in_idx_o,
    input  tap_idx_o,
    input  out_idx_o,
    input  first_o,
    input  last_o,
    output beat_ready_i
  );
endinterface

// File: rtl/conv1d_ctrl_fsm.sv
// Conv1d sequencer: turns a start strobe + (len, ksize) into one (in, tap) beat per MAC.
// Latency: first beat valid the cycle after start; status/irq one cycle after the event.
// Backpressure: beat fields registered and held while beat_valid_o & !beat_ready_i.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   start_i, abort_i    one-cycle control strobes from the register block
//   len_i, ksize_i      configuration, sampled on an accepted start
//   done_clr_i          clears the sticky done/err flags
//   beat                beat bus to the datapath (master modport)
//   drain_done_i        datapath has written its final result
//   busy_o, done_o, err_o, irq_o  status back to the register block
module conv1d_ctrl_fsm #(
  parameter int LEN_W = 16,
  parameter int K_W   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [LEN_W-1:0]          len_i,
  input  logic [K_W-1:0]            ksize_i,
  input  logic                      done_clr_i,
  conv1d_ctrl_fsm_if.master         beat,
  input  logic                      drain_done_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [K_W-1:0]   K_ONE   = {{(K_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  state_e           w_state_nxt;

  // Captured configuration.
  logic [LEN_W-1:0] r_len;
  logic [K_W-1:0]   r_ksize;

  // Window counters and the registered beat fields derived from them.
  logic [K_W-1:0]   r_tap;
  logic [LEN_W-1:0] r_out_idx;
  logic [LEN_W-1:0] r_in_idx;
  logic             r_first;
  logic             r_last;

  // Sticky status and the interrupt pulse.
  logic             r_done;
  logic             r_err;
  logic             r_irq;

  logic [LEN_W-1:0] w_ksize_i_ext;
  logic [LEN_W-1:0] w_rksize_ext;
  logic             w_cfg_bad;
  logic             w_start_idle;
  logic             w_start_ok;
  logic             w_xfer;
  logic             w_tap_last;
  logic             w_win_last;
  logic             w_last_beat;
  logic             w_abort;
  logic             w_complete;
  logic [K_W-1:0]   w_tap_nxt;
  logic [LEN_W-1:0] w_out_nxt;
  logic [LEN_W-1:0] w_tap_nxt_ext;

  // ---------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------
  assign w_ksize_i_ext = {{(LEN_W-K_W){1'b0}}, ksize_i};
  assign w_rksize_ext  = {{(LEN_W-K_W){1'b0}}, r_ksize};

  // A kernel longer than the input would give zero (or negative) outputs.
  assign w_cfg_bad    = (ksize_i == '0) || (w_ksize_i_ext > len_i);
  assign w_start_idle = (r_state == ST_IDLE) && start_i;
  assign w_start_ok   = w_start_idle && !w_cfg_bad;

  // Valid is a pure decode of the RUN state, so a transfer is RUN & ready.
  assign w_xfer      = (r_state == ST_RUN) && beat.beat_ready_i;
  assign w_tap_last  = (r_tap == (r_ksize - K_ONE));
  assign w_win_last  = (r_out_idx == (r_len - w_rksize_ext));
  assign w_last_beat = w_xfer && w_tap_last && w_win_last;

  // Abort only acts while busy and outranks both a transfer and drain_done_i.
  assign w_abort    = abort_i && (r_state != ST_IDLE);
  assign w_complete = (r_state == ST_DRAIN) && drain_done_i && !abort_i;

  // Counter values after a transfer.
  assign w_tap_nxt     = w_tap_last ? '0 : (r_tap + K_ONE);
  assign w_out_nxt     = w_tap_last ? (r_out_idx + LEN_ONE) : r_out_idx;
  assign w_tap_nxt_ext = {{(LEN_W-K_W){1'b0}}, w_tap_nxt};

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort_i)          w_state_nxt = ST_IDLE;
        else if (w_last_beat) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort_i || drain_done_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (decoded from registers only; no path from beat_ready_i)
  // ---------------------------------------------------------------------
  always_comb begin
    beat.beat_valid_o = 1'b0;
    busy_o            = 1'b0;
    beat.in_idx_o     = r_in_idx;
    beat.tap_idx_o    = r_tap;
    beat.out_idx_o    = r_out_idx;
    beat.first_o      = r_first;
    beat.last_o       = r_last;
    done_o            = r_done;
    err_o             = r_err;
    irq_o             = r_irq;
    unique case (r_state)
      ST_RUN: begin
        beat.beat_valid_o = 1'b1;
        busy_o            = 1'b1;
      end
      ST_DRAIN: begin
        busy_o = 1'b1;
      end
      default: begin
        beat.beat_valid_o = 1'b0;
        busy_o            = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Configuration capture: any start seen in IDLE, legal or not
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_len   <= '0;
      r_ksize <= '0;
    end else if (w_start_idle) begin
      r_len   <= len_i;
      r_ksize <= ksize_i;
    end
  end

  // ---------------------------------------------------------------------
  // Window counters and registered beat fields
  // ---------------------------------------------------------------------
  // The fields are recomputed from the post-transfer counter values so they
  // are ready in the same cycle the counters move; during a stall nothing is
  // written and the bus holds. Leaving RUN for any reason parks them at 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tap     <= '0;
      r_out_idx <= '0;
      r_in_idx  <= '0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
    end else if (w_start_ok) begin
      r_tap     <= '0;
      r_out_idx <= '0;
      r_in_idx  <= '0;
      r_first   <= 1'b1;
      r_last    <= (ksize_i == K_ONE);
    end else if (w_abort || w_complete || w_last_beat) begin
      r_tap     <= '0;
      r_out_idx <= '0;
      r_in_idx  <= '0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
    end else if (w_xfer) begin
      r_tap     <= w_tap_nxt;
      r_out_idx <= w_out_nxt;
      r_in_idx  <= w_out_nxt + w_tap_nxt_ext;
      r_first   <= (w_tap_nxt == '0);
      r_last    <= (w_tap_nxt == (r_ksize - K_ONE));
    end
  end

  // ---------------------------------------------------------------------
  // Sticky status and interrupt
  // ---------------------------------------------------------------------
  // Later assignments win: a completion in the same cycle as done_clr_i
  // leaves done set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      if (done_clr_i) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      if (w_start_idle) begin
        r_done <= 1'b0;
        r_err  <= w_cfg_bad;
        r_irq  <= w_cfg_bad;
      end
      if (w_complete) begin
        r_done <= 1'b1;
        r_irq  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv1d_ctrl_fsm.sv
// Directed bench for conv1d_ctrl_fsm: legal runs, stalls, bad configs, abort, async reset.
// Inputs driven #1 after the rising edge; outputs sampled at that same point.
// Expected beats come from a nested (out, tap) loop plus a hand-written in_idx table.
module tb_conv1d_ctrl_fsm;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] len;
  logic [3:0]  ksize;
  logic        done_clr;
  logic        drain_done;
  logic        busy;
  logic        done;
  logic        err;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  int          seen_in[$];
  int          exp_in_8_3[18] = '{0,1,2, 1,2,3, 2,3,4, 3,4,5, 4,5,6, 5,6,7};
  logic [15:0] stall_pat = 16'b0110_1001_1101_0011;

  conv1d_ctrl_fsm_if #(.LEN_W(16), .K_W(4)) bif ();

  conv1d_ctrl_fsm #(.LEN_W(16), .K_W(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .len_i        (len),
    .ksize_i      (ksize),
    .done_clr_i   (done_clr),
    .beat         (bif),
    .drain_done_i (drain_done),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .irq_o        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int l, input int k);
    len   = 16'(l);
    ksize = 4'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Consume beats while valid; check each accepted beat and hold during stalls.
  task automatic run_beats(input int k, input bit stall, output int nbeats, output int ncyc);
    int          eo;
    int          et;
    logic [37:0] cur;
    logic [37:0] held;
    logic [37:0] expv;
    bit          prev_stall;
    bit          rdy;
    eo = 0; et = 0; nbeats = 0; ncyc = 0; prev_stall = 0; held = '0;
    seen_in.delete();
    while (bif.beat_valid_o === 1'b1 && ncyc < 200) begin
      cur = {bif.in_idx_o, bif.tap_idx_o, bif.out_idx_o, bif.first_o, bif.last_o};
      if (prev_stall) chk("stall_hold", 64'(cur), 64'(held));
      rdy = stall ? stall_pat[ncyc % 16] : 1'b1;
      bif.beat_ready_i = rdy;
      if (rdy) begin
        expv = {16'(eo + et), 4'(et), 16'(eo), (et == 0), (et == k - 1)};
        chk("beat", 64'(cur), 64'(expv));
        seen_in.push_back(int'(bif.in_idx_o));
        nbeats++;
        if (et == k - 1) begin
          et = 0;
          eo++;
        end else begin
          et++;
        end
      end
      held       = cur;
      prev_stall = !rdy;
      tick();
      ncyc++;
    end
    bif.beat_ready_i = 1'b0;
  endtask

  // Called just after the final beat: hold off drain_done for dly cycles.
  task automatic drain(input int dly, input bit clr);
    repeat (dly) begin
      chk("drain_wait", 64'({bif.beat_valid_o, busy, done, irq}), 64'(4'b0100));
      tick();
    end
    drain_done = 1'b1;
    done_clr   = clr;
    tick();
    drain_done = 1'b0;
    done_clr   = 1'b0;
    chk("complete", 64'({busy, done, err, irq}), 64'(4'b0101));
    tick();
    chk("irq_once", 64'({busy, done, irq}), 64'(3'b010));
  endtask

  task automatic bad_cfg(input int l, input int k);
    start_job(l, k);
    chk("bad_flags", 64'({err, irq, done, busy, bif.beat_valid_o}), 64'(5'b11000));
    tick();
    chk("bad_irq_end", 64'({err, irq, busy, bif.beat_valid_o}), 64'(4'b1000));
    tick();
    chk("bad_no_valid", 64'({err, busy, bif.beat_valid_o}), 64'(3'b100));
  endtask

  initial begin
    int nb;
    int nc;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; len = '0; ksize = '0;
    done_clr = 1'b0; drain_done = 1'b0; bif.beat_ready_i = 1'b0;
    tick(); tick();
    chk("reset_state", 64'({bif.beat_valid_o, busy, done, err, irq, bif.first_o, bif.last_o,
                            bif.in_idx_o, bif.tap_idx_o, bif.out_idx_o}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Stray drain_done / abort in IDLE do nothing.
    drain_done = 1'b1; abort = 1'b1;
    tick();
    drain_done = 1'b0; abort = 1'b0;
    chk("idle_ignore", 64'({busy, done, irq, bif.beat_valid_o}), 64'd0);

    // len=8, ksize=3, ready held high.
    start_job(8, 3);
    run_beats(3, 1'b0, nb, nc);
    chk("8x3_beats", 64'(nb), 64'd18);
    chk("8x3_cycles", 64'(nc), 64'd18);
    chk("8x3_in_count", 64'(seen_in.size()), 64'd18);
    for (int i = 0; i < 18 && i < seen_in.size(); i++)
      chk("8x3_in_idx", 64'(seen_in[i]), 64'(exp_in_8_3[i]));
    drain(3, 1'b0);

    // len=4, ksize=4: one window; start clears done; done_clr loses to completion.
    start_job(4, 4);
    chk("start_clr_done", 64'(done), 64'd0);
    run_beats(4, 1'b0, nb, nc);
    chk("4x4_beats", 64'(nb), 64'd4);
    drain(1, 1'b1);

    // len=5, ksize=1: first and last on every beat.
    start_job(5, 1);
    run_beats(1, 1'b0, nb, nc);
    chk("5x1_beats", 64'(nb), 64'd5);
    drain(0, 1'b0);

    // len=6, ksize=2 with a fixed stall pattern (tenth ready at cycle 16).
    start_job(6, 2);
    run_beats(2, 1'b1, nb, nc);
    chk("6x2_beats", 64'(nb), 64'd10);
    chk("6x2_cycles", 64'(nc), 64'd17);
    drain(2, 1'b0);

    // Bad configurations.
    bad_cfg(8, 0);
    bad_cfg(4, 5);
    done_clr = 1'b1;
    tick();
    done_clr = 1'b0;
    chk("err_clr", 64'({err, done}), 64'd0);

    // Abort on the 7th beat; a start during RUN is ignored.
    start_job(8, 3);
    bif.beat_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        len = 16'd4; ksize = 4'd4; start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk("beat7_fields", 64'({bif.beat_valid_o, bif.in_idx_o, bif.tap_idx_o, bif.out_idx_o}),
        64'({1'b1, 16'd2, 4'd0, 16'd2}));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    bif.beat_ready_i = 1'b0;
    chk("abort_idle", 64'({bif.beat_valid_o, busy, done, irq,
                           bif.in_idx_o, bif.tap_idx_o, bif.out_idx_o}), 64'd0);
    tick();
    chk("abort_no_irq", 64'({busy, done, irq}), 64'd0);

    // Restart completes normally.
    start_job(8, 3);
    run_beats(3, 1'b0, nb, nc);
    chk("restart_beats", 64'(nb), 64'd18);
    drain(3, 1'b0);

    // Asynchronous reset in the middle of RUN.
    start_job(5, 1);
    bif.beat_ready_i = 1'b1;
    tick();
    chk("pre_reset_busy", 64'({busy, bif.beat_valid_o, bif.in_idx_o}), 64'({2'b11, 16'd1}));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 64'({bif.beat_valid_o, busy, done, err, irq, bif.first_o, bif.last_o,
                            bif.in_idx_o, bif.tap_idx_o, bif.out_idx_o}), 64'd0);
    bif.beat_ready_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", 64'({busy, bif.beat_valid_o}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
